// File: rtl/kalman_pkg.sv
// -----------------------------------------------------------------------------
// kalman_pkg
// Shared types and default sizes for the Kalman filter datapath blocks.
//   arb_state_e : sequencing states of the shared matrix-vector multiplier
//   KF_WIDTH    : default element width (two's complement)
//   KF_NOS      : default matrix/vector dimension
// -----------------------------------------------------------------------------
package kalman_pkg;

    localparam int KF_WIDTH = 16;
    localparam int KF_NOS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/matvec_arbiter_if.sv
// -----------------------------------------------------------------------------
// matvec_arbiter_if
// Bus between the arbiter and the single shared n x 1 matrix-vector multiplier.
//   mult_start : one-cycle start pulse (arbiter -> multiplier)
//   mult_A     : NOS x NOS x WIDTH matrix operand, element (i,j) at (i*NOS+j)*WIDTH
//   mult_B     : NOS x WIDTH vector operand, element i at i*WIDTH
//   mult_end   : one-cycle completion pulse (multiplier -> arbiter)
//   mult_res   : NOS x WIDTH result, valid while mult_end = 1
// Modports: master = arbiter side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface matvec_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NOS   = 4
);

    logic                       mult_start;
    logic [NOS*NOS*WIDTH-1:0]   mult_A;
    logic [NOS*WIDTH-1:0]       mult_B;
    logic                       mult_end;
    logic [NOS*WIDTH-1:0]       mult_res;

    modport master (
        output mult_start,
        output mult_A,
        output mult_B,
        input  mult_end,
        input  mult_res
    );

    modport slave (
        input  mult_start,
        input  mult_A,
        input  mult_B,
        output mult_end,
        output mult_res
    );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: first set request at or after ptr_i,
// wrapping from NREQ-1 back to 0.
//   req_i : request vector
//   ptr_i : highest-priority index this round (must be < NREQ)
//   gnt_o : one-hot winner (all zero when nothing requested)
//   idx_o : binary index of the winner
//   any_o : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int c;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr_i) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = PW'(c);
            end
        end
    end

endmodule

// File: rtl/matvec_arbiter.sv
// -----------------------------------------------------------------------------
// matvec_arbiter
// Round-robin arbiter/sequencer sharing one matrix-vector multiplier among
// NREQ requesters. Latches the winner's operands, pulses start, captures the
// result and returns a one-cycle done to the owner. A watchdog ends an
// operation with err if the multiplier never answers.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level request per requester, held until its done
//   req_A/req_B: per-requester operands, requester r at r*(operand width)
//   gnt        : one-hot owner, valid START through DONE
//   done       : one-cycle one-hot completion pulse to owner
//   err        : one-cycle pulse together with done on watchdog expiry
//   res        : last successful result, held
//   busy       : state != IDLE
//   mult       : master side of the multiplier bus
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no owner; pick next requester from rr_ptr, latch its operands
// START  | mult_start high for this cycle only; watchdog cleared
// WAIT   | waiting for mult_end; watchdog counts up to TIMEOUT
// DONE   | done (and err on timeout) to owner; rr_ptr moves past owner
// -----------------------------------------------------------------------------
module matvec_arbiter
    import kalman_pkg::*;
#(
    parameter int WIDTH   = KF_WIDTH,
    parameter int NOS     = KF_NOS,
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*NOS*NOS*WIDTH-1:0] req_A,
    input  logic [NREQ*NOS*WIDTH-1:0]     req_B,
    output logic [NREQ-1:0]               gnt,
    output logic [NREQ-1:0]               done,
    output logic                          err,
    output logic [NOS*WIDTH-1:0]          res,
    output logic                          busy,
    matvec_arbiter_if.master              mult
);

    localparam int AW  = NOS * NOS * WIDTH;
    localparam int BW  = NOS * WIDTH;
    localparam int PW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
    localparam logic [PW-1:0]  LAST_IDX = PW'(NREQ - 1);

    arb_state_e       state_q;
    logic [PW-1:0]    owner_q;
    logic [PW-1:0]    rr_ptr_q;
    logic [PW-1:0]    rr_ptr_d;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_q;
    logic             err_q;
    logic             busy_q;
    logic             start_q;
    logic [AW-1:0]    mult_A_q;
    logic [BW-1:0]    mult_B_q;
    logic [BW-1:0]    res_q;
    logic [WDW-1:0]   wd_q;

    logic [NREQ-1:0]  pick_gnt;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Priority moves to the requester after the one just served.
    assign rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            mult_A_q <= '0;
            mult_B_q <= '0;
            res_q    <= '0;
            wd_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner_q  <= pick_idx;
                        gnt_q    <= pick_gnt;
                        mult_A_q <= req_A[pick_idx*AW +: AW];
                        mult_B_q <= req_B[pick_idx*BW +: BW];
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    start_q <= 1'b0;
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real end wins over an expiring watchdog in the same cycle.
                    if (mult.mult_end) begin
                        res_q   <= mult.mult_res;
                        done_q  <= gnt_q;
                        state_q <= ST_DONE;
                    end else if (wd_q == WD_LIMIT) begin
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q   <= '0;
                    err_q    <= 1'b0;
                    gnt_q    <= '0;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt             = gnt_q;
    assign done            = done_q;
    assign err             = err_q;
    assign res             = res_q;
    assign busy            = busy_q;
    assign mult.mult_start = start_q;
    assign mult.mult_A     = mult_A_q;
    assign mult.mult_B     = mult_B_q;

endmodule

// File: tb/tb_matvec_arbiter.sv
module tb_matvec_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int R  = 3;
    localparam int TO = 8;
    localparam int AW = N * N * W;
    localparam int BW = N * W;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [R-1:0]    req   = '0;
    logic [R*AW-1:0] req_A = '0;
    logic [R*BW-1:0] req_B = '0;
    logic [R-1:0]    gnt;
    logic [R-1:0]    done;
    logic            err;
    logic            busy;
    logic [BW-1:0]   res;

    int n_checks = 0;
    int n_pass   = 0;

    matvec_arbiter_if #(.WIDTH(W), .NOS(N)) mif ();

    matvec_arbiter #(
        .WIDTH   (W),
        .NOS     (N),
        .NREQ    (R),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .req_A (req_A),
        .req_B (req_B),
        .gnt   (gnt),
        .done  (done),
        .err   (err),
        .res   (res),
        .busy  (busy),
        .mult  (mif)
    );

    always #5 clk = ~clk;

    // Multiplier model: end pulses NOS+1 cycles after the start cycle.
    // Not reset by rst_n, like an independent multiplier block.
    logic          pend      = 1'b0;
    int            cnt       = 0;
    logic [BW-1:0] mres      = '0;
    logic          mult_en   = 1'b1;
    logic          stray_end = 1'b0;

    function automatic logic [BW-1:0] matvec(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0]       r;
        int                  acc;
        logic signed [W-1:0] ea;
        logic signed [W-1:0] eb;
        r = '0;
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                ea  = a[(i*N+j)*W +: W];
                eb  = b[j*W +: W];
                acc = acc + int'(ea) * int'(eb);
            end
            r[i*W +: W] = W'(acc);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (mif.mult_start) begin
            pend <= 1'b1;
            cnt  <= N;
            mres <= matvec(mif.mult_A, mif.mult_B);
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end

    assign mif.mult_end = (pend && cnt == 0 && mult_en) || stray_end;
    assign mif.mult_res = mres;

    function automatic logic [AW-1:0] diag(input int d);
        logic [AW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[(i*N+i)*W +: W] = W'(d);
        return m;
    endfunction

    function automatic logic [BW-1:0] vec(input int a0, input int a1, input int a2, input int a3);
        logic [BW-1:0] v;
        v = '0;
        v[0*W +: W] = W'(a0);
        v[1*W +: W] = W'(a1);
        v[2*W +: W] = W'(a2);
        v[3*W +: W] = W'(a3);
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req       = '0;
        mult_en   = 1'b1;
        stray_end = 1'b0;
        rst_n     = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done === '0 && cycles < 40) begin
            tick;
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (gnt !== 3'b000) $display("FAIL reset_gnt: got %b expected 000", gnt); else n_pass++;
        n_checks++; if (done !== 3'b000) $display("FAIL reset_done: got %b expected 000", done); else n_pass++;
        n_checks++; if ({err, busy, mif.mult_start} !== 3'b000) $display("FAIL reset_flags: got err/busy/start %b expected 000", {err, busy, mif.mult_start}); else n_pass++;
        n_checks++; if (res !== '0) $display("FAIL reset_res: got %h expected 0", res); else n_pass++;
        n_checks++; if ({mif.mult_A, mif.mult_B} !== '0) $display("FAIL reset_operands: got A=%h B=%h expected 0", mif.mult_A, mif.mult_B); else n_pass++;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_single;
        int cyc;
        do_reset;
        req_A[0 +: AW] = diag(1);
        req_B[0 +: BW] = vec(1, 2, 3, 4);
        req = 3'b001;
        tick;
        n_checks++; if (gnt !== 3'b001) $display("FAIL single_gnt: got %b expected 001", gnt); else n_pass++;
        n_checks++; if (mif.mult_start !== 1'b1) $display("FAIL single_start: got %b expected 1", mif.mult_start); else n_pass++;
        n_checks++; if (mif.mult_A !== diag(1) || mif.mult_B !== vec(1, 2, 3, 4)) $display("FAIL single_operands: got A=%h B=%h expected A=%h B=%h", mif.mult_A, mif.mult_B, diag(1), vec(1, 2, 3, 4)); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
        tick;
        n_checks++; if (mif.mult_start !== 1'b0) $display("FAIL single_start_pulse: got %b expected 0", mif.mult_start); else n_pass++;
        wait_done(cyc);
        n_checks++; if (cyc + 2 != 7) $display("FAIL single_latency: got %0d expected 7", cyc + 2); else n_pass++;
        n_checks++; if (done !== 3'b001) $display("FAIL single_done: got %b expected 001", done); else n_pass++;
        n_checks++; if (res !== vec(1, 2, 3, 4)) $display("FAIL single_res: got %h expected %h", res, vec(1, 2, 3, 4)); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL single_err: got %b expected 0", err); else n_pass++;
        req = '0;
        tick;
        n_checks++; if ({done, gnt, busy} !== 7'b0) $display("FAIL single_after: got done=%b gnt=%b busy=%b expected all 0", done, gnt, busy); else n_pass++;
    endtask

    task automatic test_contention;
        logic [BW-1:0] exp_res [R];
        logic [R-1:0]  exp_g;
        int            cyc;
        do_reset;
        req_A[0*AW +: AW] = diag(1);  req_B[0*BW +: BW] = vec(1, 2, 3, 4);
        req_A[1*AW +: AW] = diag(2);  req_B[1*BW +: BW] = vec(1, 1, 1, 1);
        req_A[2*AW +: AW] = diag(1);  req_B[2*BW +: BW] = vec(-1, -2, -3, -4);
        exp_res[0] = vec(1, 2, 3, 4);
        exp_res[1] = vec(2, 2, 2, 2);
        exp_res[2] = vec(-1, -2, -3, -4);
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp_g = R'(1) << (k % R);
            cyc = 0;
            while (gnt === '0 && cyc < 20) begin
                tick;
                cyc++;
            end
            n_checks++; if (gnt !== exp_g) $display("FAIL contention_gnt[%0d]: got %b expected %b", k, gnt, exp_g); else n_pass++;
            if (k > 0) begin
                n_checks++; if (cyc + 1 != 2) $display("FAIL contention_gap[%0d]: got %0d expected 2", k, cyc + 1); else n_pass++;
            end
            wait_done(cyc);
            n_checks++; if (done !== exp_g) $display("FAIL contention_done[%0d]: got %b expected %b", k, done, exp_g); else n_pass++;
            n_checks++; if (res !== exp_res[k % R]) $display("FAIL contention_res[%0d]: got %h expected %h", k, res, exp_res[k % R]); else n_pass++;
            req = req & ~exp_g;
            tick;
            req = 3'b111;
        end
        req = '0;
        tick;
        tick;
    endtask

    task automatic test_stability;
        int cyc;
        do_reset;
        req_A[0 +: AW] = diag(2);
        req_B[0 +: BW] = vec(-1, 5, 0, 7);
        req = 3'b001;
        tick;
        req_A[0 +: AW] = diag(5);
        req_B[0 +: BW] = vec(9, 9, 9, 9);
        req = 3'b000;
        tick;
        n_checks++; if (mif.mult_A !== diag(2) || mif.mult_B !== vec(-1, 5, 0, 7)) $display("FAIL stable_operands: got A=%h B=%h expected A=%h B=%h", mif.mult_A, mif.mult_B, diag(2), vec(-1, 5, 0, 7)); else n_pass++;
        wait_done(cyc);
        n_checks++; if (done !== 3'b001) $display("FAIL stable_done_after_drop: got %b expected 001", done); else n_pass++;
        n_checks++; if (res !== vec(-2, 10, 0, 14)) $display("FAIL stable_res: got %h expected %h", res, vec(-2, 10, 0, 14)); else n_pass++;
        tick;
        tick;
        n_checks++; if ({gnt, busy} !== 4'b0) $display("FAIL stable_no_regrant: got gnt=%b busy=%b expected 0", gnt, busy); else n_pass++;
    endtask

    task automatic test_timeout;
        int cyc;
        do_reset;
        req_A[0 +: AW] = diag(1);
        req_B[0 +: BW] = vec(1, 2, 3, 4);
        req = 3'b001;
        tick;
        wait_done(cyc);
        req = '0;
        tick;
        mult_en = 1'b0;
        req_A[AW +: AW] = diag(3);
        req_B[BW +: BW] = vec(1, 1, 1, 1);
        req = 3'b010;
        tick;
        n_checks++; if (gnt !== 3'b010) $display("FAIL timeout_gnt: got %b expected 010", gnt); else n_pass++;
        wait_done(cyc);
        n_checks++; if (cyc != TO + 2) $display("FAIL timeout_latency: got %0d expected %0d", cyc, TO + 2); else n_pass++;
        n_checks++; if (done !== 3'b010 || err !== 1'b1) $display("FAIL timeout_done_err: got done=%b err=%b expected 010/1", done, err); else n_pass++;
        n_checks++; if (res !== vec(1, 2, 3, 4)) $display("FAIL timeout_res_held: got %h expected %h", res, vec(1, 2, 3, 4)); else n_pass++;
        req = '0;
        tick;
        n_checks++; if (err !== 1'b0 || done !== 3'b000) $display("FAIL timeout_pulse: got err=%b done=%b expected 0/000", err, done); else n_pass++;
        mult_en = 1'b1;
    endtask

    task automatic test_reset_mid_wait;
        int cyc;
        int bad;
        do_reset;
        req_A[0 +: AW] = diag(1);
        req_B[0 +: BW] = vec(1, 2, 3, 4);
        req = 3'b001;
        tick;
        wait_done(cyc);
        req = '0;
        tick;
        req_A[AW +: AW] = diag(1);
        req_B[BW +: BW] = vec(4, 3, 2, 1);
        req = 3'b010;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({gnt, done, err, busy, mif.mult_start} !== 9'b0) $display("FAIL midwait_ctrl: got gnt=%b done=%b err=%b busy=%b start=%b expected 0", gnt, done, err, busy, mif.mult_start); else n_pass++;
        n_checks++; if (res !== '0 || mif.mult_A !== '0 || mif.mult_B !== '0) $display("FAIL midwait_data: got res=%h B=%h expected 0", res, mif.mult_B); else n_pass++;
        req = '0;
        tick;
        tick;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            stray_end = (i == 3);
            tick;
            if (done !== '0 || busy !== 1'b0) bad++;
        end
        stray_end = 1'b0;
        n_checks++; if (bad != 0) $display("FAIL midwait_stray_end: got %0d bad cycles expected 0", bad); else n_pass++;
        req = 3'b111;
        tick;
        n_checks++; if (gnt !== 3'b001) $display("FAIL midwait_ptr_reset: got %b expected 001", gnt); else n_pass++;
        wait_done(cyc);
        n_checks++; if (done !== 3'b001 || res !== vec(1, 2, 3, 4)) $display("FAIL midwait_next_op: got done=%b res=%h expected 001 %h", done, res, vec(1, 2, 3, 4)); else n_pass++;
        req = '0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_stability;
        test_timeout;
        test_reset_mid_wait;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no end of test expected finish before 100000");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/matvec_arbiter.md
# matvec_arbiter

Round-robin arbiter and sequencer that shares one n×1 matrix-vector multiplier (start/end handshake, accumulating signed product, NOS+1-cycle busy window) among NREQ requesters in the Kalman filter datapath. Prediction (F·x), measurement projection (H·x) and gain application (K·y) request the single multiplier instance through this block. It latches the granted operands, issues the start pulse, captures the result, and returns a completion pulse to the owner. A watchdog reports a multiplier that never ends.

## Interface
Parameters:
- WIDTH, 16, element width (two's complement)
- NOS, 4, matrix/vector dimension
- NREQ, 3, number of requesters (≥2)
- TIMEOUT, 64, max cycles in WAIT before error

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  level request per requester; held until its done
- req_A  in  NREQ×NOS×NOS×WIDTH  matrix operand per requester
- req_B  in  NREQ×NOS×WIDTH  vector operand per requester
- gnt  out  NREQ  one-hot owner, valid START through DONE
- done  out  NREQ  one-hot, one-cycle completion pulse to owner
- err  out  1  one-cycle pulse with done on timeout
- res  out  NOS×WIDTH  last successful result, held
- busy  out  1  state ≠ IDLE
- mult_start  out  1  one-cycle start to multiplier
- mult_A  out  NOS×NOS×WIDTH  latched matrix operand
- mult_B  out  NOS×WIDTH  latched vector operand
- mult_end  in  1  multiplier completion pulse
- mult_res  in  NOS×WIDTH  multiplier result, valid when mult_end=1

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- IDLE: if any req bit set, choose first set bit at or after rr_ptr (wrapping NREQ-1→0); register owner index, gnt, mult_A/mult_B ← that requester's operands; →START. Else stay.
- START: mult_start=1 for exactly this cycle; clear watchdog; →WAIT.
- WAIT: watchdog increments each cycle. On mult_end: res ← mult_res; →DONE. If watchdog reaches TIMEOUT without mult_end: res unchanged, set timeout flag; →DONE.
- DONE: done[owner]=1; err=1 if timeout flag; rr_ptr ← owner+1 (wrap); gnt cleared on exit; →IDLE.
- mult_A/mult_B change only on the IDLE→START transition; stable through the whole op regardless of req_A/req_B changes.
- req dropped mid-operation: ignored; the operation completes and done still pulses.
- mult_end in IDLE, START or DONE: ignored.
- Pure routing, no arithmetic on data; res is a bit-exact copy of mult_res.
- Reset (any state, asynchronous): state=IDLE, gnt=0, done=0, err=0, busy=0, mult_start=0, mult_A=0, mult_B=0, res=0, rr_ptr=0, watchdog=0. A late mult_end from an unreset multiplier is then ignored in IDLE.

## Timing
- req sampled high in IDLE at cycle t → gnt and mult_start at t+1 → shared multiplier asserts mult_end at t+NOS+2 → done/res valid at t+NOS+3. Total latency NOS+3 (7 for NOS=4).
- Back-to-back: DONE→IDLE costs one cycle; next grant is at earliest 2 cycles after done.
- Requester deasserts req by the edge following its done cycle; a req still high in the following IDLE cycle is treated as a new request.
- Simultaneous requests: round-robin only; none starves; worst-case wait is (NREQ-1)·(NOS+4) cycles.
- Timeout: done+err at START+TIMEOUT+2.
- Watchdog width: $clog2(TIMEOUT+1).

## Structure
- Shared package kalman_pkg: state enum type (IDLE/START/WAIT/DONE), default WIDTH/NOS constants.
- Sub-module rr_pick: combinational, takes req vector and rr_ptr, returns one-hot grant and index plus any-valid flag. All other logic stays in matvec_arbiter.

## Test plan
- Single request: req=001, A=identity, B={1,2,3,4}, with the real multiplier attached → gnt=001 at t+1, done=001 at t+7, res={1,2,3,4}, err=0.
- Contention: req=111 held, each requester re-raising after its done → grant order 0,1,2,0; each done one-hot to the granted requester.
- Operand stability: change req_A[0] in the cycle after grant → res reflects the latched operands; A=2·I, B={-1,5,0,7} gives {-2,10,0,14}.
- Timeout: stub multiplier never asserts mult_end, TIMEOUT=8 → done+err at START+10; res keeps its previous value.
- Reset mid-WAIT: rst_n low 2 cycles → all outputs 0 immediately; stray mult_end afterwards → no done; next req served normally from rr_ptr=0.
